// File: rtl/booth_seq_ctrl_if.sv
// rtl/booth_seq_ctrl_if.sv - request/result bundle for the sequential Booth multiplier
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       m_in;
  logic [WIDTH-1:0]       q_in;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, m_in, q_in,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, m_in, q_in,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - radix-2 Booth sequential signed multiplier, one bit per cycle
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  booth_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // Accumulator and multiplicand carry one guard bit so -2^(WIDTH-1) negates cleanly
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       a_sum;
  logic [WIDTH-1:0]     qr_q, qr_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Next-state and datapath: accept in IDLE, one add/sub + arithmetic shift per ITER cycle
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    qr_d      = qr_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    a_sum     = a_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {bus.m_in[WIDTH-1], bus.m_in};
          a_d     = '0;
          qr_d    = bus.q_in;
          qm1_d   = 1'b0;
          count_d = CW'(WIDTH);
          state_d = ITER;
        end
      end

      ITER: begin
        case ({qr_q[0], qm1_q})
          2'b01:   a_sum = a_q + m_q;
          2'b10:   a_sum = a_q - m_q;
          default: a_sum = a_q;
        endcase
        a_d     = {a_sum[WIDTH], a_sum[WIDTH:1]};
        qr_d    = {a_sum[0], qr_q[WIDTH-1:1]};
        qm1_d   = qr_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {a_d[WIDTH-1:0], qr_d};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      qr_q      <= qr_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == ITER);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - self-checking bench for booth_seq_ctrl
module tb_booth_seq_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int a;
    int b;
    a = $signed(m);
    b = $signed(q);
    return 16'(a * b);
  endfunction

  // Reference: an accepted request yields W busy cycles, then one done cycle carrying M*Q
  bit          mdl_active = 1'b0;
  int          mdl_t = 0;
  logic [15:0] mdl_exp = '0;
  logic [15:0] mdl_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_active = 1'b0;
      mdl_t      = 0;
      mdl_prod   = '0;
    end else if (mdl_active) begin
      mdl_t++;
      if (mdl_t == W) mdl_prod = mdl_exp;
      if (mdl_t == W + 1) mdl_active = 1'b0;
    end else if (bus.start) begin
      mdl_active = 1'b1;
      mdl_t      = 0;
      mdl_exp    = ref_mul(bus.m_in, bus.q_in);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(bus.busy), 32'(mdl_active && (mdl_t < W)));
      check("cyc_done", 32'(bus.done), 32'(mdl_active && (mdl_t == W)));
      check("cyc_product", 32'(bus.product), 32'(mdl_prod));
    end
  end

  // Called at a negedge; issues one request and waits (bounded) for its done pulse
  task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input string name);
    int lat;
    int nbusy;
    bit got;
    lat   = 0;
    nbusy = 0;
    got   = 1'b0;
    bus.start = 1'b1;
    bus.m_in  = m;
    bus.q_in  = q;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.m_in  = ~m;
        bus.q_in  = ~q;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    check({name, "_got_done"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(W));
    check({name, "_product"}, 32'(bus.product), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] rm;
    logic [7:0] rq;
    int held_dones;

    bus.start = 1'b0;
    bus.m_in  = '0;
    bus.q_in  = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd15,  8'd15,  16'h00E1, "m15_q15");
    run_op(8'hFF,  8'd6,   16'hFFFA, "mneg1_q6");
    run_op(8'd0,   8'd1,   16'h0000, "m0_q1");
    run_op(8'hFD,  8'd6,   16'hFFEE, "mneg3_q6");
    run_op(8'h80,  8'h80,  16'h4000, "mmin_qmin");
    run_op(8'h80,  8'h7F,  16'hC080, "mmin_qmax");

    // Abort on the 4th ITER cycle, then restart on the first edge with rst low
    bus.start = 1'b1;
    bus.m_in  = 8'd50;
    bus.q_in  = 8'd50;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    run_op(8'd3, 8'hFD, 16'hFFF7, "after_abort");

    // start held high: results every W+2 cycles, operands scrambled while iterating
    held_dones = 0;
    bus.start = 1'b1;
    bus.m_in  = 8'd5;
    bus.q_in  = 8'd7;
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      check("held_done_slot", 32'(bus.done), 32'((i % 10) == 9));
      if (bus.done) held_dones++;
      if (i == 9) check("held_first_product", 32'(bus.product), 32'd35);
      if (i == 29) begin
        bus.start = 1'b0;
      end else begin
        bus.m_in = 8'($urandom);
        bus.q_in = 8'($urandom);
      end
    end
    check("held_done_count", 32'(held_dones), 32'd3);
    @(negedge clk);

    for (int k = 0; k < 400; k++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      run_op(rm, rq, ref_mul(rm, rq), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (product is 2*WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 m_in  input  WIDTH  multiplicand M, two's complement signed.
REQ-006 q_in  input  WIDTH  multiplier Q, two's complement signed.
REQ-007 busy  output  1  high while iterations are in progress (ITER state).
REQ-008 done  output  1  one-cycle pulse; product valid and new this cycle.
REQ-009 product  output  2*WIDTH  registered signed result M*Q; holds until next done.

Function
REQ-010 FSM states SHALL be IDLE, ITER, DONE; encoding free; no other reachable states.
REQ-011 IDLE with start=1 at a clock edge SHALL latch m_in/q_in, load A=0, Qreg=q_in, q_m1=0, count=WIDTH, and move to ITER.
REQ-012 IDLE with start=0 SHALL remain in IDLE with all datapath registers unchanged.
REQ-013 Accumulator A SHALL be WIDTH+1 bits, M sign-extended to WIDTH+1, so that M=-2^(WIDTH-1) produces a correct result.
REQ-014 Each ITER edge SHALL examine {Qreg[0],q_m1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged; all arithmetic modulo 2^(WIDTH+1).
REQ-015 In the same edge, {A,Qreg,q_m1} SHALL be shifted right one bit arithmetically, with the updated A's MSB replicated, and count decremented by 1.
REQ-016 When the ITER edge decrements count from 1 to 0, the FSM SHALL move to DONE and load product with {A[WIDTH-1:0],Qreg} of the post-shift value.
REQ-017 Exactly WIDTH ITER cycles SHALL occur per operation; done SHALL be high exactly WIDTH+1 cycles after the edge that sampled start.
REQ-018 DONE SHALL last one cycle with done=1, busy=0, then return unconditionally to IDLE.
REQ-019 start SHALL be ignored in ITER and DONE; no queuing; operands changing during ITER SHALL not affect the result.
REQ-020 A new start is accepted no earlier than the first IDLE cycle after DONE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 busy SHALL equal (state==ITER); done SHALL equal (state==DONE); both are derived from registered state only.
REQ-022 product SHALL change only on entry to DONE or on reset.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, product=0, A=0, Qreg=0, q_m1=0, count=0.
REQ-024 rst SHALL take priority over start and over any in-progress iteration; an aborted operation produces no done pulse.
REQ-025 The first start after rst deasserts SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-026 M=15, Q=15, start pulse -> busy high 8 cycles, done 9 cycles after start, product=16'h00E1 (225).
REQ-027 M=-1, Q=6 -> product=16'hFFFA (-6); M=0, Q=1 -> product=16'h0000; M=-3, Q=6 -> product=16'hFFEE (-18).
REQ-028 Corner operands: M=-128, Q=-128 -> product=16'h4000 (16384); M=-128, Q=127 -> product=16'hC080 (-16256).
REQ-029 Start held high continuously with operands changed during ITER -> only first operands used; results at exactly every 10 cycles.
REQ-030 rst asserted on the 4th ITER cycle -> busy=0, product=0, no done; then M=3, Q=-3 -> done after 9 cycles, product=16'hFFF7 (-9).
REQ-031 Exhaustive or random sweep of all 65536 signed 8-bit operand pairs -> product matches the reference signed product every time, with fixed latency.
